seg_scan_display: RTL and testbench
===================================

Name: seg_scan_display

Overview:
- Parametrised multi-channel 7-segment scan driver.
- Takes CHANNELS unsigned binary values and converts each to BCD with a sequential shift-add-3 engine.
- Holds the resulting digits in a double-buffered digit store and time-multiplexes them onto one shared active-low segment bus with active-low anodes.
- Sits between the counting/score logic and the board display pins.

Parameters:
- CHANNELS, 2: number of independent values shown.
- CH_W, 10: bit width of each channel value.
- CH_DIGITS, 3: decimal digits per channel. NUM_DIGITS = CHANNELS*CH_DIGITS, legal range 1..8.
- SCAN_DIV, 4: clk cycles each digit stays lit. Legal range ≥2.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous reset, active low.
- val  in  CHANNELS*CH_W  packed channel values; channel k occupies val[k*CH_W +: CH_W].
- upd  in  1  update request strobe; sampled every cycle.
- busy  out  1  conversion in progress.
- ovf  out  CHANNELS  per-channel overflow flag from the last completed conversion.
- SEG  out  8  segments, active low; SEG[7]=dp, SEG[6:0]=g..a.
- AN  out  NUM_DIGITS  digit enables, active low, one-hot-cold.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - SEG=all ones, AN=all ones, busy=0, ovf=0.
  - Digit store cleared to 0. FSM=IDLE. Prescaler=0, digit index=0, pending=0.
  - Reset mid-conversion abandons it; the store is not written.
- Converter FSM:
  - IDLE:
    - If upd=1 or pending=1, capture val into the shift register, clear pending, busy=1 next cycle, go to CONV.
    - Otherwise stay in IDLE.
  - CONV:
    - All channels in parallel. Each cycle: add 3 to every BCD nibble ≥5, then shift left one bit.
    - Runs exactly CH_W cycles, counted by a bit counter, then goes to LOAD.
  - LOAD (1 cycle):
    - Writes all channels' digits and ovf into the display store atomically.
    - Goes to IDLE with busy=0.
    - Total latency from the accepting upd edge to the store update: CH_W+2 cycles.
  - upd=1 while busy=1 sets pending (a single-entry request memory). Further requests merge into it. The pending request captures val freshly when serviced.
- Width and overflow:
  - The BCD accumulator holds enough nibbles for 2^CH_W−1.
  - If a channel value > 10^CH_DIGITS−1: ovf[k]=1 and that channel's digits all display dash (segment g only).
  - Otherwise only the low CH_DIGITS nibbles are stored.
- Scan:
  - The prescaler counts 0..SCAN_DIV−1.
  - At terminal count, the digit index advances and wraps NUM_DIGITS−1 → 0.
  - In the cycle the index changes, AN=all ones and SEG=all ones (ghost blanking).
  - On the next cycle, AN[idx]=0 and SEG shows the decoded store digit for idx.
  - Digit mapping: digit j of channel k (j=0 is least significant) is at AN index k*CH_DIGITS+j.
- Decode:
  - Codes 0..9 give standard patterns; the dash code gives g only; the blank code gives all segments off.
  - dp is always off (SEG[7]=1).
- Timing rule: a store update in LOAD is visible no earlier than the next digit slot. No torn display of a channel is allowed.

Optional Feature:
- Macro: SEG_LZ_BLANK_EN.
- Defined: within each non-overflowed channel, zero digits above the most significant non-zero digit show blank. Digit 0 of each channel always shows, so value 0 displays as a single "0". Blanking is computed in LOAD and stored as the blank code.
- Undefined: all digits always shown, including leading zeros. The blank code is used only for reset and ghost blanking.

Decomposition:
- Package seg_disp_pkg holds:
  - the 4-bit digit code constants (0..9, CODE_DASH, CODE_BLANK);
  - the 7-segment pattern constant table;
  - the FSM state enum (IDLE, CONV, LOAD).
- Sub-module bin2bcd_seq: a one-channel sequential shift-add-3 converter with start/done and an overflow output, instantiated CHANNELS times under a generate loop.
- Scan, decode and FSM control stay in the top.

Test Plan:
- Reset, then hold rst_n=1 for 3*SCAN_DIV*NUM_DIGITS cycles with no upd. Expect: AN cycles one-hot-cold through 6 digits. SEG shows "0" on every digit without the macro, and "0" on digits 0 and 3 only with SEG_LZ_BLANK_EN.
- val={ch1=10'd123, ch0=10'd7}, upd pulse. Expect: busy high for 12 cycles. Store then reads ch1=1,2,3 and ch0=0,0,7 (ch0 shows blank,blank,7 with the macro). ovf=0.
- ch0=10'd1000, ch1=10'd999, upd. Expect: ovf=2'b01, ch0 shows three dashes, ch1 shows 9,9,9.
- upd at cycle 0, val changed to ch0=5 and upd pulsed at cycle 4 (busy). Expect: a second conversion starts the cycle after LOAD and captures ch0=5. Exactly two conversions occur.
- Assert rst_n=0 mid-CONV (cycle 6). Expect: next cycle busy=0, AN=all ones, SEG=all ones, store unchanged from the reset value.
- Sample at every AN index change. Expect: exactly one blank cycle with AN=all ones, and never two AN bits low simultaneously.

Source files
------------

// File: rtl/seg_scan_display_pkg.sv
// Shared digit codes, 7-segment pattern table and converter FSM states
// for the seg_scan_display block.
package seg_disp_pkg;

  localparam logic [3:0] CODE_0     = 4'd0;
  localparam logic [3:0] CODE_1     = 4'd1;
  localparam logic [3:0] CODE_2     = 4'd2;
  localparam logic [3:0] CODE_3     = 4'd3;
  localparam logic [3:0] CODE_4     = 4'd4;
  localparam logic [3:0] CODE_5     = 4'd5;
  localparam logic [3:0] CODE_6     = 4'd6;
  localparam logic [3:0] CODE_7     = 4'd7;
  localparam logic [3:0] CODE_8     = 4'd8;
  localparam logic [3:0] CODE_9     = 4'd9;
  localparam logic [3:0] CODE_DASH  = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  // Active-high g..a patterns indexed by digit code; unused codes are dark.
  localparam logic [6:0] SEG_PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_e;

  // Decimal digits needed to hold 2^w - 1.
  function automatic int dec_digits(input int w);
    longint v;
    int     n;
    v = (longint'(1) << w) - 1;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      if (v >= 10) begin
        v = v / 10;
        n = n + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// Request/status bundle between the value producer and seg_scan_display.
interface seg_scan_display_if #(
  parameter int CHANNELS = 2,
  parameter int CH_W     = 10
);
  logic [CHANNELS*CH_W-1:0] val;
  logic                     upd;
  logic                     busy;
  logic [CHANNELS-1:0]      ovf;

  modport master (output val, output upd, input busy, input ovf);
  modport slave  (input val, input upd, output busy, output ovf);
endinterface

// File: rtl/seg_scan_display_bin2bcd_seq.sv
// One-channel sequential shift-add-3 binary to BCD converter; done_o pulses
// one cycle after the last of the CH_W shift steps.
module bin2bcd_seq
  import seg_disp_pkg::*;
#(
  parameter int CH_W      = 10,
  parameter int CH_DIGITS = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [CH_W-1:0]        val_i,
  output logic                   done_o,
  output logic [CH_DIGITS*4-1:0] digits_o,
  output logic                   ovf_o
);

  localparam int BIN_N = dec_digits(CH_W);
  localparam int ACC_N = (BIN_N > CH_DIGITS) ? BIN_N : CH_DIGITS;
  localparam int CNT_W = $clog2(CH_W + 1);

  logic [ACC_N*4-1:0] bcd_q, bcd_d, adj;
  logic [CH_W-1:0]    bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               run_q, run_d;
  logic               done_q, done_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < ACC_N; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    bcd_d  = bcd_q;
    bin_d  = bin_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (start_i) begin
      bcd_d = '0;
      bin_d = val_i;
      cnt_d = CNT_W'(CH_W);
      run_d = 1'b1;
    end else if (run_q) begin
      {bcd_d, bin_d} = {adj, bin_q} << 1;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd_q  <= '0;
      bin_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      bcd_q  <= bcd_d;
      bin_q  <= bin_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done_o   = done_q;
  assign digits_o = bcd_q[CH_DIGITS*4-1:0];

  // Any non-zero nibble above the displayed digits means the value does not fit.
  if (ACC_N > CH_DIGITS) begin : g_ovf
    assign ovf_o = |bcd_q[ACC_N*4-1:CH_DIGITS*4];
  end else begin : g_no_ovf
    assign ovf_o = 1'b0;
  end

endmodule

// File: rtl/seg_scan_display.sv
// Multi-channel BCD conversion plus multiplexed 7-segment scan driver.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
//
// state | meaning
// IDLE  | waiting for upd or a pending request
// CONV  | converters shifting, waiting for done
// LOAD  | write digits and ovf into the back store
module seg_scan_display
  import seg_disp_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int CH_W      = 10,
  parameter int CH_DIGITS = 3,
  parameter int SCAN_DIV  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  seg_scan_display_if.slave             bus,
  output logic [7:0]                    SEG,
  output logic [CHANNELS*CH_DIGITS-1:0] AN
);

  localparam int ND = CHANNELS * CH_DIGITS;
  localparam int IW = (ND > 1) ? $clog2(ND) : 1;
  localparam int PW = $clog2(SCAN_DIV);

`ifdef SEG_LZ_BLANK_EN
  localparam bit LZ_EN = 1'b1;
`else
  localparam bit LZ_EN = 1'b0;
`endif

  function automatic logic [ND*4-1:0] rst_store();
    logic [ND*4-1:0] st;
    for (int i = 0; i < ND; i++) begin
      st[4*i +: 4] = (LZ_EN && (i % CH_DIGITS != 0)) ? CODE_BLANK : CODE_0;
    end
    return st;
  endfunction

  localparam logic [ND*4-1:0] RST_STORE = rst_store();

  state_e                  state_q, state_d;
  logic                    pend_q, pend_d;
  logic [CHANNELS-1:0]     ovf_q, ovf_d;
  logic [ND*4-1:0]         back_q, back_d, front_q, front_d, load_digits;
  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [7:0]              seg_q, seg_d;
  logic [ND-1:0]           an_q, an_d;
  logic                    start, tc, wrap, lead;
  logic [3:0]              dig, cur_code;
  logic [ND*4-1:0]         cvt_dig;
  logic [CHANNELS-1:0]     cvt_ovf, cvt_done;

  assign start = (state_q == IDLE) && (bus.upd || pend_q);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_cvt
    bin2bcd_seq #(
      .CH_W      (CH_W),
      .CH_DIGITS (CH_DIGITS)
    ) u_cvt (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (start),
      .val_i    (bus.val[k*CH_W +: CH_W]),
      .done_o   (cvt_done[k]),
      .digits_o (cvt_dig[k*CH_DIGITS*4 +: CH_DIGITS*4]),
      .ovf_o    (cvt_ovf[k])
    );
  end

  // Walk each channel from its top digit down so leading zeros can be blanked.
  always_comb begin
    load_digits = '0;
    lead        = 1'b1;
    dig         = CODE_0;
    for (int k = 0; k < CHANNELS; k++) begin
      lead = 1'b1;
      for (int j = CH_DIGITS - 1; j >= 0; j--) begin
        dig = cvt_dig[(k*CH_DIGITS + j)*4 +: 4];
        if (cvt_ovf[k]) begin
          load_digits[(k*CH_DIGITS + j)*4 +: 4] = CODE_DASH;
        end else if (LZ_EN && lead && (j != 0) && (dig == CODE_0)) begin
          load_digits[(k*CH_DIGITS + j)*4 +: 4] = CODE_BLANK;
        end else begin
          load_digits[(k*CH_DIGITS + j)*4 +: 4] = dig;
          lead = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    back_d  = back_q;
    case (state_q)
      IDLE: begin
        if (bus.upd || pend_q) begin
          state_d = CONV;
          pend_d  = 1'b0;
        end
      end
      CONV: begin
        if (bus.upd) pend_d = 1'b1;
        if (&cvt_done) state_d = LOAD;
      end
      LOAD: begin
        if (bus.upd) pend_d = 1'b1;
        back_d  = load_digits;
        ovf_d   = cvt_ovf;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The front store only takes the back store at frame wrap, so a channel never tears.
  assign tc       = (presc_q == PW'(SCAN_DIV - 1));
  assign wrap     = (idx_q == IW'(ND - 1));
  assign cur_code = front_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    presc_d = tc ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    front_d = front_q;
    seg_d   = {1'b1, ~SEG_PAT[cur_code]};
    an_d    = ~(ND'(1) << idx_q);
    if (tc) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
      seg_d = '1;
      an_d  = '1;
      if (wrap) front_d = back_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      ovf_q   <= '0;
      back_q  <= RST_STORE;
      front_q <= RST_STORE;
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= '1;
      an_q    <= '1;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      back_q  <= back_d;
      front_q <= front_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.ovf  = ovf_q;
  assign SEG      = seg_q;
  assign AN       = an_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with a scoreboard of expected displays.
module tb_seg_scan_display;

  localparam int CHANNELS  = 2;
  localparam int CH_W      = 10;
  localparam int CH_DIGITS = 3;
  localparam int SCAN_DIV  = 4;
  localparam int ND        = CHANNELS * CH_DIGITS;
  localparam int FRAME     = ND * SCAN_DIV;

  typedef struct packed {
    logic [ND*8-1:0]     seg;
    logic [CHANNELS-1:0] ovf;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [7:0]    SEG;
  logic [ND-1:0] AN;
  exp_t          sb[$];
  exp_t          e;
  int            checks;
  int            errors;
  int            gap;
  int            hi;
  int            cnt;

  seg_scan_display_if #(.CHANNELS(CHANNELS), .CH_W(CH_W)) bus_if ();

  seg_scan_display #(
    .CHANNELS  (CHANNELS),
    .CH_W      (CH_W),
    .CH_DIGITS (CH_DIGITS),
    .SCAN_DIV  (SCAN_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave),
    .SEG   (SEG),
    .AN    (AN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] digit_pat(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic exp_t model(input int v0, input int v1);
    exp_t r;
    int   v;
    int   d;
    logic [7:0] pat;
`ifdef SEG_LZ_BLANK_EN
    int   top;
`endif
    r = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      v = (k == 0) ? v0 : v1;
      if (v > 999) begin
        r.ovf[k] = 1'b1;
        for (int j = 0; j < CH_DIGITS; j++) r.seg[(k*CH_DIGITS + j)*8 +: 8] = 8'hBF;
      end else begin
`ifdef SEG_LZ_BLANK_EN
        top = (v >= 100) ? 2 : (v >= 10) ? 1 : 0;
`endif
        for (int j = 0; j < CH_DIGITS; j++) begin
          d   = (j == 0) ? v % 10 : (j == 1) ? (v / 10) % 10 : v / 100;
          pat = digit_pat(d);
`ifdef SEG_LZ_BLANK_EN
          if (j > top) pat = 8'hFF;
`endif
          r.seg[(k*CH_DIGITS + j)*8 +: 8] = pat;
        end
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at a negedge; counts low samples before busy rises, then high samples.
  task automatic wait_conv(output int g, output int h);
    g = 0;
    h = 0;
    while (bus_if.busy !== 1'b1 && g < 100) begin
      g++;
      @(negedge clk);
    end
    while (bus_if.busy === 1'b1 && h < 100) begin
      h++;
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input exp_t x, input int ncyc);
    logic [ND-1:0] an;
    logic [ND-1:0] prev;
    logic [ND-1:0] seen;
    logic [7:0]    sg;
    int            zeros;
    int            idx;
    prev = AN;
    seen = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      an    = AN;
      sg    = SEG;
      zeros = 0;
      idx   = 0;
      for (int i = 0; i < ND; i++) begin
        if (!an[i]) begin
          zeros++;
          idx = i;
        end
      end
      check("an_one_hot_cold", 64'(zeros <= 1), 64'd1);
      if (zeros == 0) begin
        check("ghost_seg_blank", 64'(sg), 64'hFF);
        check("single_blank_cycle", 64'(prev != '1), 64'd1);
      end else begin
        check("digit_seg", 64'(sg), 64'(x.seg[idx*8 +: 8]));
        if (prev != '1) check("blank_between_digits", 64'(an), 64'(prev));
        seen[idx] = 1'b1;
      end
      prev = an;
    end
    check("all_digits_seen", 64'(seen), 64'({ND{1'b1}}));
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus_if.upd   = 1'b0;
    bus_if.val   = '0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_an", 64'(AN), 64'({ND{1'b1}}));
    check("reset_seg", 64'(SEG), 64'hFF);
    check("reset_busy", 64'(bus_if.busy), 64'd0);
    check("reset_ovf", 64'(bus_if.ovf), 64'd0);
    rst_n = 1'b1;
    check_frame(model(0, 0), 3 * FRAME);

    // Plain conversion: ch1=123, ch0=7
    tick();
    bus_if.val = {10'd123, 10'd7};
    bus_if.upd = 1'b1;
    sb.push_back(model(7, 123));
    tick();
    bus_if.upd = 1'b0;
    @(negedge clk);
    wait_conv(gap, hi);
    check("conv1_busy_cycles", 64'(hi), 64'd12);
    e = sb.pop_front();
    check("conv1_ovf", 64'(bus_if.ovf), 64'(e.ovf));
    repeat (30) @(negedge clk);
    check_frame(e, FRAME + 4);

    // Overflowing channel: ch1=999, ch0=1000
    tick();
    bus_if.val = {10'd999, 10'd1000};
    bus_if.upd = 1'b1;
    sb.push_back(model(1000, 999));
    tick();
    bus_if.upd = 1'b0;
    @(negedge clk);
    wait_conv(gap, hi);
    check("conv2_busy_cycles", 64'(hi), 64'd12);
    e = sb.pop_front();
    check("conv2_ovf", 64'(bus_if.ovf), 64'(e.ovf));
    repeat (30) @(negedge clk);
    check_frame(e, FRAME + 4);

    // Requests while busy merge into one pending conversion
    tick();
    bus_if.val = {10'd42, 10'd1020};
    bus_if.upd = 1'b1;
    sb.push_back(model(1020, 42));
    tick();
    bus_if.upd = 1'b0;
    repeat (3) tick();
    bus_if.val = {10'd42, 10'd5};
    bus_if.upd = 1'b1;
    sb.push_back(model(5, 42));
    repeat (3) tick();
    bus_if.upd = 1'b0;
    @(negedge clk);
    wait_conv(gap, hi);
    check("pend_first_remaining", 64'(hi), 64'd6);
    e = sb.pop_front();
    check("pend_first_ovf", 64'(bus_if.ovf), 64'(e.ovf));
    wait_conv(gap, hi);
    check("pend_idle_gap", 64'(gap), 64'd1);
    check("pend_second_busy", 64'(hi), 64'd12);
    e = sb.pop_front();
    check("pend_second_ovf", 64'(bus_if.ovf), 64'(e.ovf));
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus_if.busy === 1'b1) cnt++;
    end
    check("no_third_conv", 64'(cnt), 64'd0);
    check_frame(e, FRAME + 4);

    // Reset in the middle of a conversion
    tick();
    bus_if.val = {10'd500, 10'd600};
    bus_if.upd = 1'b1;
    tick();
    bus_if.upd = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("midrst_busy", 64'(bus_if.busy), 64'd0);
    check("midrst_an", 64'(AN), 64'({ND{1'b1}}));
    check("midrst_seg", 64'(SEG), 64'hFF);
    check("midrst_ovf", 64'(bus_if.ovf), 64'd0);
    rst_n = 1'b1;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus_if.busy === 1'b1) cnt++;
    end
    check("midrst_abandoned", 64'(cnt), 64'd0);
    check_frame(model(0, 0), FRAME + 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
